// File: rtl/param_shift_queue.sv
// Parametrised shift queue: DATA_W-bit entries shift through DEPTH lanes and are
// emitted as one packed word with a valid/ready handshake, flush and drop counting.

module param_shift_queue_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end
endmodule

module param_shift_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EN,
  input  logic [DATA_W-1:0]        data,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*DEPTH-1:0]  Data_Q,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic                     out_partial,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0][DATA_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]             count, count_nxt;
  logic                         partial, partial_nxt;
  logic                         accept, emit;

  assign accept = (state == FILL) && EN;
  assign emit   = (state == HOLD) && out_ready;

  // Lane 0 is R1 (newest entry); each accept moves every lane up by one.
  for (genvar k = 0; k < DEPTH; k++) begin : g_lane
    if (k == 0) begin : g_head
      assign lane_d[k] = data;
    end else begin : g_body
      assign lane_d[k] = lane_q[k-1];
    end
    param_shift_queue_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .clear (emit),
      .d     (lane_d[k]),
      .q     (lane_q[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      count   <= '0;
      partial <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      partial <= partial_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    partial_nxt = partial;
    case (state)
      FILL: begin
        if (accept) count_nxt = count + CNT_W'(1);
        // A flush only closes a packet that will hold at least one entry.
        if ((count_nxt == CNT_W'(DEPTH)) || (flush && (count_nxt != '0))) begin
          state_nxt   = HOLD;
          partial_nxt = (count_nxt != CNT_W'(DEPTH));
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt   = FILL;
          count_nxt   = '0;
          partial_nxt = 1'b0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if ((state == HOLD) && EN && (drop_cnt != {DROP_W{1'b1}}))
      drop_cnt <= drop_cnt + DROP_W'(1);
  end

  assign in_ready    = (state == FILL);
  assign out_valid   = (state == HOLD);
  assign Data_Q      = lane_q;
  assign out_count   = count;
  assign out_partial = partial;
endmodule

// File: doc/param_shift_queue.md
Name: param_shift_queue

Overview:
Parametrised successor to the fixed 4-byte shift queue. DATA_W-bit entries shift in through a DEPTH-stage register chain (Data -> R1 -> ... -> R_DEPTH) and are presented as one packed DATA_W*DEPTH word. The block adds a valid/ready output handshake, input backpressure, flush of partial packets, an entry count, and a saturating drop counter. It sits between a byte-serial producer and a word-wide consumer in the datapath.

Parameters:
DATA_W, 8, width of one entry.
DEPTH, 4, number of entries per packed word (>= 2).
DROP_W, 8, width of the saturating drop counter.
CNT_W is a derived localparam equal to $clog2(DEPTH+1).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
EN  input  1  input strobe; data is valid this cycle.
data  input  DATA_W  input entry.
in_ready  output  1  block can accept an entry this cycle.
flush  input  1  close the current packet early.
out_valid  output  1  Data_Q holds a completed packet.
out_ready  input  1  consumer takes Data_Q.
Data_Q  output  DATA_W*DEPTH  packed word {R_DEPTH,...,R2,R1}; R1 is in the low lane.
out_count  output  CNT_W  number of valid entries in Data_Q (1..DEPTH when out_valid is high).
out_partial  output  1  the packet was closed by flush with fewer than DEPTH entries.
drop_cnt  output  DROP_W  count of EN strobes refused.

Behaviour:
- Reset (asynchronous, rst=1): R1..R_DEPTH=0, count=0, state=FILL. Outputs: out_valid=0, out_partial=0, out_count=0, drop_cnt=0, in_ready=1, Data_Q=0.
- State FILL: in_ready=1, out_valid=0.
  - Accept when EN=1: R1<=data, Rk<=R(k-1) for k=2..DEPTH, count<=count+1.
  - When the accepted entry makes count==DEPTH: go to HOLD with out_partial=0.
  - flush=1 with count>0 and no accept: go to HOLD with out_partial=1.
  - flush=1 and EN=1 together: the entry is accepted first, then the packet closes. out_partial=1 only if the new count<DEPTH.
  - flush=1 with count==0 and EN=0: ignored, no state change.
- Partial packet layout: entries occupy the lanes that were shifted; untouched upper lanes read 0, because registers are cleared on each emit. The oldest entry is in lane out_count-1.
- State HOLD: out_valid=1, in_ready=0, Data_Q/out_count/out_partial stable. flush is ignored.
  - When out_ready=1: on the edge, all R are cleared, count=0, out_partial=0, and the state goes to FILL.
  - in_ready returns to 1 in the following cycle. No same-cycle pass-through.
- Latency: the DEPTH-th accept at edge n gives out_valid=1 in the cycle after edge n. Back-to-back throughput is DEPTH entries per DEPTH+1 cycles.
- out_count equals count and is visible in both states.
- Drops: EN=1 while in_ready=0 increments drop_cnt, saturating at 2^DROP_W-1. The data is discarded.
- Reset asserted mid-packet or mid-HOLD: everything clears immediately. drop_cnt also clears.
- Inputs are sampled only on the rising edge of clk. There are no combinational paths from inputs to outputs except through registers.

Test Plan:
- Fill: reset, then EN with data 0x11,0x22,0x33,0x44 on consecutive cycles and out_ready=0 -> out_valid=1 one cycle after the 4th accept. Required: Data_Q=0x11223344, out_count=4, out_partial=0, in_ready=0.
- Handshake/hold: keep out_ready=0 for 5 cycles with EN=1 -> Data_Q stays 0x11223344 and drop_cnt=5. Then out_ready=1 for 1 cycle -> next cycle out_valid=0, Data_Q=0, in_ready=1.
- Flush: accept 0xAA,0xBB, then flush=1 -> Data_Q=0x0000AABB, out_count=2, out_partial=1. Separately, flush with count=0 -> no out_valid.
- Simultaneous: accept 0x01,0x02,0x03, then EN=1 (0x04) with flush=1 -> Data_Q=0x01020304, out_count=4, out_partial=0. Separately, after one entry, EN+flush -> out_count=2, out_partial=1.
- Saturation: DROP_W=2, hold in HOLD and strobe EN 6 times -> drop_cnt=3.
- Async reset: assert rst between clock edges after 2 accepts -> outputs clear immediately, before the next edge. After release, a full 4-entry packet emits correctly.
